// File: rtl/cursor_pkg.sv
// -----------------------------------------------------------------------------
// cursor_pkg
//   Shared types for the paint-canvas cursor controller.
//   - dir_t        : per-axis step direction after opposing buttons cancel
//   - axis_state_t : per-axis press / hold / autorepeat state
//   - rgb444_t     : 12-bit cursor colour
//   - buttons_t    : the four direction buttons as one packed record
//   - decode_dir() : turns a (positive, negative) button pair into dir_t
// -----------------------------------------------------------------------------
package cursor_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_NEG  = 2'd1,
        DIR_POS  = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        AX_IDLE   = 2'd0,
        AX_HOLD   = 2'd1,
        AX_REPEAT = 2'd2
    } axis_state_t;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } buttons_t;

    // Exactly one button of the pair gives a direction; neither or both
    // pressed means the axis stands still.
    function automatic dir_t decode_dir(input logic pos_btn, input logic neg_btn);
        case ({pos_btn, neg_btn})
            2'b10:   decode_dir = DIR_POS;
            2'b01:   decode_dir = DIR_NEG;
            default: decode_dir = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cursor_ctrl_if.sv
// -----------------------------------------------------------------------------
// cursor_ctrl_if
//   Bundles the cursor controller's button inputs and cursor outputs.
//   Parameters must match the cursor_ctrl instance it is attached to.
//   Signals:
//     b_up/b_down/b_left/b_right : debounced button levels (async to clk)
//     cursor_x / cursor_y        : current column / row
//     cursor_pixel               : cursor_y*WIDTH + cursor_x
//     cursor_colour              : constant RGB444 cursor colour
//     moved                      : one-cycle pulse after the position changed
//   Modports:
//     master : button source, cursor consumer (pixel writer / VGA overlay)
//     slave  : the cursor controller itself
// -----------------------------------------------------------------------------
interface cursor_ctrl_if #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15
);
    import cursor_pkg::*;

    logic                      b_up;
    logic                      b_down;
    logic                      b_left;
    logic                      b_right;
    logic [$clog2(WIDTH)-1:0]  cursor_x;
    logic [$clog2(HEIGHT)-1:0] cursor_y;
    logic [ADDR_W-1:0]         cursor_pixel;
    rgb444_t                   cursor_colour;
    logic                      moved;

    modport master (
        output b_up, b_down, b_left, b_right,
        input  cursor_x, cursor_y, cursor_pixel, cursor_colour, moved
    );

    modport slave (
        input  b_up, b_down, b_left, b_right,
        output cursor_x, cursor_y, cursor_pixel, cursor_colour, moved
    );

endinterface

// File: rtl/axis_stepper.sv
// -----------------------------------------------------------------------------
// axis_stepper
//   One cursor axis: press/hold/autorepeat FSM, repeat timer and the
//   clamp-or-wrap position register for the range [0, MAX].
//   Ports:
//     clk       : system clock
//     reset     : synchronous, active-high
//     dir_i     : synchronised direction request for this axis
//     pos_o     : registered position
//     changed_o : high in the cycle whose clock edge will change pos_o
// -----------------------------------------------------------------------------
module axis_stepper
    import cursor_pkg::*;
#(
    parameter int  MAX           = 159,
    parameter int  START         = 80,
    parameter int  HOLD_DELAY    = 12_500_000,
    parameter int  REPEAT_PERIOD = 2_500_000,
    parameter bit  WRAP          = 1'b0,
    localparam int POS_W         = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  dir_t             dir_i,
    output logic [POS_W-1:0] pos_o,
    output logic             changed_o
);

    localparam int TMR_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_DELAY - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [POS_W-1:0] POS_MAX     = POS_W'(MAX);
    localparam logic [POS_W-1:0] POS_START   = POS_W'(START);

    axis_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    dir_t             dir_q;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step;

    logic [POS_W:0]   nxt_ext;
    logic             out_of_range;
    logic [POS_W-1:0] step_pos;

    // Press / hold / repeat sequencing. A change of direction while held
    // counts as a fresh press; releasing (or cancelling) always drops to IDLE
    // with the timer cleared, so the timer only runs while a button is held.
    always_comb begin
        // NOTE: every signal driven here gets a default before the case, so no
        // path through the block can leave it unassigned and infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        step    = 1'b0;

        case (state_q)
            AX_IDLE: begin
                timer_d = '0;
                if (dir_i != DIR_NONE) begin
                    step    = 1'b1;
                    state_d = AX_HOLD;
                end
            end

            AX_HOLD: begin
                if (dir_i == DIR_NONE) begin
                    state_d = AX_IDLE;
                    timer_d = '0;
                end else if (dir_i != dir_q) begin
                    step    = 1'b1;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = AX_REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            AX_REPEAT: begin
                if (dir_i == DIR_NONE) begin
                    state_d = AX_IDLE;
                    timer_d = '0;
                end else if (dir_i != dir_q) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = AX_HOLD;
                end else if (timer_q == REPEAT_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = AX_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Position datapath. The step is done one bit wider than the position: a
    // decrement from 0 borrows into the extra bit and an increment from MAX
    // lands on MAX+1, so a single unsigned compare against MAX catches both
    // edges of the canvas.
    always_comb begin
        if (dir_i == DIR_POS) begin
            nxt_ext = {1'b0, pos_q} + 1'b1;
        end else begin
            nxt_ext = {1'b0, pos_q} - 1'b1;
        end

        out_of_range = (nxt_ext > {1'b0, POS_MAX});

        if (!out_of_range) begin
            step_pos = nxt_ext[POS_W-1:0];
        end else if (WRAP) begin
            step_pos = (dir_i == DIR_POS) ? '0 : POS_MAX;
        end else begin
            step_pos = pos_q;
        end

        pos_d = step ? step_pos : pos_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AX_IDLE;
            timer_q <= '0;
            dir_q   <= DIR_NONE;
            pos_q   <= POS_START;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_i;
            pos_q   <= pos_d;
        end
    end

    assign pos_o     = pos_q;
    // A clamped step leaves the position alone and so reports no change.
    assign changed_o = (pos_d != pos_q);

endmodule

// File: rtl/cursor_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_ctrl
//   X/Y cursor controller for the paint canvas. Four direction buttons move
//   the cursor one pixel per press, with hold-to-autorepeat, clamping or
//   wrapping at the canvas edges. Produces the linear frame-buffer address and
//   the cursor colour for the pixel writer and VGA overlay.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high
//     bus   : cursor_ctrl_if.slave - buttons in; cursor_x, cursor_y,
//             cursor_pixel, cursor_colour, moved out
// -----------------------------------------------------------------------------
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int      WIDTH         = 160,
    parameter int      HEIGHT        = 120,
    parameter int      ADDR_W        = 15,
    parameter int      HOLD_DELAY    = 12_500_000,
    parameter int      REPEAT_PERIOD = 2_500_000,
    parameter bit      WRAP          = 1'b0,
    parameter int      START_X       = 80,
    parameter int      START_Y       = 60,
    parameter rgb444_t COLOUR        = 12'hFFF
) (
    input  logic         clk,
    input  logic         reset,
    cursor_ctrl_if.slave bus
);

    localparam int                X_W     = $clog2(WIDTH);
    localparam int                Y_W     = $clog2(HEIGHT);
    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);

    buttons_t       sync1_q, sync2_q;
    dir_t           dir_x, dir_y;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic           changed_x, changed_y;
    logic           moved_q, moved_d;

    // Two-flop synchronisers for the asynchronous button levels. They are
    // cleared by reset so a button held through reset cannot leak a step
    // into the first cycles afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q.up    <= bus.b_up;
            sync1_q.down  <= bus.b_down;
            sync1_q.left  <= bus.b_left;
            sync1_q.right <= bus.b_right;
            sync2_q       <= sync1_q;
        end
    end

    // Screen coordinates: right and down are the positive directions.
    assign dir_x = decode_dir(sync2_q.right, sync2_q.left);
    assign dir_y = decode_dir(sync2_q.down,  sync2_q.up);

    axis_stepper #(
        .MAX           (WIDTH - 1),
        .START         (START_X),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .WRAP          (WRAP)
    ) u_axis_x (
        .clk       (clk),
        .reset     (reset),
        .dir_i     (dir_x),
        .pos_o     (pos_x),
        .changed_o (changed_x)
    );

    axis_stepper #(
        .MAX           (HEIGHT - 1),
        .START         (START_Y),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .WRAP          (WRAP)
    ) u_axis_y (
        .clk       (clk),
        .reset     (reset),
        .dir_i     (dir_y),
        .pos_o     (pos_y),
        .changed_o (changed_y)
    );

    // The changed flags describe the coming edge, so registering them makes
    // moved rise together with the new coordinates and last one cycle.
    assign moved_d = changed_x | changed_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            moved_q <= 1'b0;
        end else begin
            moved_q <= moved_d;
        end
    end

    assign bus.cursor_x      = pos_x;
    assign bus.cursor_y      = pos_y;
    // Both coordinates are always in range, so the address stays below
    // WIDTH*HEIGHT; WIDTH is a constant, so the multiply reduces to shifts/adds.
    assign bus.cursor_pixel  = ADDR_W'(pos_y) * WIDTH_A + ADDR_W'(pos_x);
    assign bus.cursor_colour = COLOUR;
    assign bus.moved         = moved_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
module tb_cursor_ctrl;
    import cursor_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;
    localparam int HD = 4;
    localparam int RP = 2;
    localparam int SX = 3;
    localparam int SY = 1;

    localparam logic [3:0] B_0 = 4'b0000;
    localparam logic [3:0] B_R = 4'b0001;
    localparam logic [3:0] B_L = 4'b0010;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_U = 4'b1000;

    logic clk;
    logic reset;

    cursor_ctrl_if #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) if_c ();
    cursor_ctrl_if #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) if_w ();

    cursor_ctrl #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP),
        .WRAP(1'b0), .START_X(SX), .START_Y(SY), .COLOUR(12'hFFF)
    ) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c)
    );

    cursor_ctrl #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP),
        .WRAP(1'b1), .START_X(SX), .START_Y(SY), .COLOUR(12'hFFF)
    ) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (if_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model. Buttons reach the axis logic two edges late.
    // Per axis, a direction that has been steady for n edges steps at
    // n == 0, n == HD, and every RP edges after that. Index 0 = clamp
    // DUT, 1 = wrap DUT; axis 0 = x, 1 = y.
    // ---------------------------------------------------------------
    int         m_pos [2][2];
    logic       m_mv  [2];
    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    int         m_prev[2];
    int         m_run [2];

    function automatic int axis_dir(input logic p, input logic n);
        return int'(p) - int'(n);
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] btn);
        int  d[2];
        bit  stp[2];
        int  lim[2];
        int  nxt;
        int  old_x, old_y;
        lim = '{W - 1, H - 1};
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_pos[i][0] = SX;
                m_pos[i][1] = SY;
                m_mv[i]     = 1'b0;
                m_prev[i]   = 0;
                m_run[i]    = 0;
            end
            m_s1 = '0;
            m_s2 = '0;
            return;
        end
        d[0] = axis_dir(m_s2[0], m_s2[1]);
        d[1] = axis_dir(m_s2[2], m_s2[3]);
        for (int a = 0; a < 2; a++) begin
            stp[a] = 1'b0;
            if (d[a] == 0) begin
                m_prev[a] = 0;
            end else if (d[a] != m_prev[a]) begin
                m_prev[a] = d[a];
                m_run[a]  = 0;
                stp[a]    = 1'b1;
            end else begin
                m_run[a]++;
                stp[a] = (m_run[a] == HD) || (m_run[a] > HD && (m_run[a] - HD) % RP == 0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            old_x = m_pos[i][0];
            old_y = m_pos[i][1];
            for (int a = 0; a < 2; a++) begin
                if (stp[a]) begin
                    nxt = m_pos[i][a] + d[a];
                    if (nxt < 0)      nxt = (i == 1) ? lim[a] : 0;
                    if (nxt > lim[a]) nxt = (i == 1) ? 0 : lim[a];
                    m_pos[i][a] = nxt;
                end
            end
            m_mv[i] = (m_pos[i][0] != old_x) || (m_pos[i][1] != old_y);
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic compare_one(input string tag, input int i, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] p, input logic [31:0] mv);
        check({tag, " x"},     x,  32'(m_pos[i][0]));
        check({tag, " y"},     y,  32'(m_pos[i][1]));
        check({tag, " pixel"}, p,  32'(m_pos[i][1] * W + m_pos[i][0]));
        check({tag, " moved"}, mv, 32'(m_mv[i]));
    endtask

    task automatic drive_buttons(input logic [3:0] btn);
        if_c.b_up = btn[3]; if_c.b_down = btn[2]; if_c.b_left = btn[1]; if_c.b_right = btn[0];
        if_w.b_up = btn[3]; if_w.b_down = btn[2]; if_w.b_left = btn[1]; if_w.b_right = btn[0];
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later and check
    // both DUTs against the model.
    task automatic tick(input logic rst, input logic [3:0] btn);
        reset = rst;
        drive_buttons(btn);
        @(posedge clk);
        #1;
        model_edge(rst, btn);
        compare_one("model clamp", 0, 32'(if_c.cursor_x), 32'(if_c.cursor_y),
                    32'(if_c.cursor_pixel), 32'(if_c.moved));
        compare_one("model wrap", 1, 32'(if_w.cursor_x), 32'(if_w.cursor_y),
                    32'(if_w.cursor_pixel), 32'(if_w.moved));
    endtask

    task automatic pulse(input logic [3:0] btn);
        tick(1'b0, btn);
        repeat (3) tick(1'b0, B_0);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        int         x;
        int         y;
        int         pix;
        logic       mv;
    } vec_t;

    vec_t vecs[$];
    int   t3_steps[4] = '{3, 7, 9, 11};

    initial begin
        int exp_x;
        int n;
        int len;
        logic [3:0] rb;
        logic exp_mv;
        logic rr;

        reset = 1'b1;
        drive_buttons(B_0);

        // Directed table on the clamping instance: reset, 1-cycle press,
        // opposing buttons cancel, diagonal press.
        vecs.push_back('{1'b1, B_0,       3, 1, 11, 1'b0});
        vecs.push_back('{1'b1, B_R,       3, 1, 11, 1'b0});
        vecs.push_back('{1'b1, B_R,       3, 1, 11, 1'b0});
        vecs.push_back('{1'b0, B_0,       3, 1, 11, 1'b0});
        vecs.push_back('{1'b0, B_0,       3, 1, 11, 1'b0});
        vecs.push_back('{1'b0, B_R,       3, 1, 11, 1'b0});
        vecs.push_back('{1'b0, B_0,       3, 1, 11, 1'b0});
        vecs.push_back('{1'b0, B_0,       4, 1, 12, 1'b1});
        vecs.push_back('{1'b0, B_0,       4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_0,       4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_L | B_R, 4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_L | B_R, 4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_L | B_R, 4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_L | B_R, 4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_0,       4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_0,       4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_D | B_R, 4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_0,       4, 1, 12, 1'b0});
        vecs.push_back('{1'b0, B_0,       5, 2, 21, 1'b1});
        vecs.push_back('{1'b0, B_0,       5, 2, 21, 1'b0});
        vecs.push_back('{1'b0, B_0,       5, 2, 21, 1'b0});

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].btn);
            check($sformatf("vec%0d x", i),     32'(if_c.cursor_x),     32'(vecs[i].x));
            check($sformatf("vec%0d y", i),     32'(if_c.cursor_y),     32'(vecs[i].y));
            check($sformatf("vec%0d pixel", i), 32'(if_c.cursor_pixel), 32'(vecs[i].pix));
            check($sformatf("vec%0d moved", i), 32'(if_c.moved),        32'(vecs[i].mv));
        end
        check("colour", 32'(if_c.cursor_colour), 32'h0000_0FFF);

        // Hold right for 20 cycles: step, 4-cycle hold, repeat every 2, clamp at 7.
        tick(1'b1, B_0);
        for (int i = 1; i <= 24; i++) begin
            tick(1'b0, (i <= 20) ? B_R : B_0);
            exp_x  = 3;
            exp_mv = 1'b0;
            foreach (t3_steps[k]) begin
                if (t3_steps[k] <= i) exp_x++;
                if (t3_steps[k] == i) exp_mv = 1'b1;
            end
            check($sformatf("hold e%0d x", i),     32'(if_c.cursor_x), 32'(exp_x));
            check($sformatf("hold e%0d moved", i), 32'(if_c.moved),    32'(exp_mv));
        end

        // Edge behaviour: clamp vs wrap at x=7 and y=0.
        tick(1'b1, B_0);
        repeat (4) pulse(B_R);
        check("edge x at 7 clamp", 32'(if_c.cursor_x), 32'd7);
        check("edge x at 7 wrap",  32'(if_w.cursor_x), 32'd7);
        tick(1'b0, B_R); tick(1'b0, B_0); tick(1'b0, B_0);
        check("edge clamp x",     32'(if_c.cursor_x), 32'd7);
        check("edge clamp moved", 32'(if_c.moved),    32'd0);
        check("edge wrap x",      32'(if_w.cursor_x), 32'd0);
        check("edge wrap moved",  32'(if_w.moved),    32'd1);
        tick(1'b0, B_0);
        pulse(B_U);
        tick(1'b0, B_U); tick(1'b0, B_0); tick(1'b0, B_0);
        check("edge clamp y",     32'(if_c.cursor_y),     32'd0);
        check("edge clamp pixel", 32'(if_c.cursor_pixel), 32'd7);
        check("edge clamp moved", 32'(if_c.moved),        32'd0);
        check("edge wrap y",      32'(if_w.cursor_y),     32'd3);
        check("edge wrap pixel",  32'(if_w.cursor_pixel), 32'd24);
        check("edge wrap moved",  32'(if_w.moved),        32'd1);
        tick(1'b0, B_0);

        // Reset in the middle of REPEAT with down held, then keep holding.
        tick(1'b1, B_0);
        for (int i = 1; i <= 8; i++) tick(1'b0, B_D);
        check("rst pre y clamp", 32'(if_c.cursor_y), 32'd3);
        check("rst pre y wrap",  32'(if_w.cursor_y), 32'd3);
        tick(1'b1, B_D);
        check("rst mid y clamp",     32'(if_c.cursor_y), 32'd1);
        check("rst mid y wrap",      32'(if_w.cursor_y), 32'd1);
        check("rst mid moved clamp", 32'(if_c.moved),    32'd0);
        for (int j = 1; j <= 7; j++) begin
            tick(1'b0, B_D);
            check($sformatf("rst post e%0d y", j), 32'(if_c.cursor_y),
                  (j >= 7) ? 32'd3 : (j >= 3) ? 32'd2 : 32'd1);
        end
        repeat (3) tick(1'b0, B_0);

        // Randomised held-button segments with occasional resets.
        n = 0;
        while (n < 3000) begin
            rb  = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                rr = ($urandom_range(0, 299) == 0);
                tick(rr, rb);
                n++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
